// File: rtl/sm_scan_pkg.sv
// Shared types and constants for the register scanner.
// scan_state_t : SETTLE (address settling), SHOW_LO / SHOW_HI (half-word pages on display).
// SEG_BLANK    : all segments and dp off (active-low).
// SEG7_LUT     : 16 active-low patterns {dp,g..a} for hex digits 0-F, dp off; entry n at bits [8n+7:8n].
// seg7()       : lookup helper into SEG7_LUT.
package sm_scan_pkg;

  typedef enum logic [1:0] {SETTLE, SHOW_LO, SHOW_HI} scan_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [127:0] SEG7_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,  // F E d C b A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0   // 7 6 5 4 3 2 1 0
  };

  function automatic logic [7:0] seg7(input logic [3:0] nibble);
    return SEG7_LUT[{nibble, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sm_hex_digit.sv
// One 7-segment digit decoder (combinational).
// Ports:
//   nibble in 4  hex value to show
//   dp_on  in 1  1 = light the decimal point
//   blank  in 1  1 = force every segment and dp off
//   seg    out 8 {dp,g..a}, active-low
module sm_hex_digit
  import sm_scan_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp_on,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    glyph = seg7(nibble);
    seg   = SEG_BLANK;
    if (!blank) begin
      seg = {~dp_on, glyph[6:0]};
    end
  end

endmodule

// File: rtl/sm_reg_scanner.sv
// Paged register scanner for the core's debug port, shown on six 7-segment digits.
// Walks regAddr 0..ADDR_MAX; for each address it waits SETTLE_CYC cycles, latches
// regData, then shows the low half-word page followed by the high half-word page.
// scan_en=1 auto-advances pages every DWELL_CYC cycles; scan_en=0 pauses and a
// one-cycle step pulse advances one page.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   scan_en      1 = auto-advance, 0 = paused
//   step         single-page advance while paused (ignored in SETTLE)
//   regAddr      address driven to the core debug port
//   regData      combinational read data for regAddr
//   hex0..hex5   active-low {dp,g..a}; hex5..4 = address, hex3..0 = half-word
//   page_hi      1 while the high half-word is shown (dp on hex4 is lit too)
//   dbg_state    current FSM state (scan_state_t encoding)
// Build option: SM_SCAN_SKIP_ZERO_EN -- addresses reading zero are skipped
// without touching the display.
module sm_reg_scanner
  import sm_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int DWELL_CYC  = 5_000_000,
  parameter int ADDR_MAX   = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        step,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5,
  output logic        page_hi,
  output logic [1:0]  dbg_state
);

  localparam int CNT_MAX = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYC - 1);
  localparam logic [4:0]       ADDR_LAST   = 5'(ADDR_MAX);

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      data_q;
  logic [4:0]       shown_addr;
  logic             blank;

  logic       page_done;
  logic [4:0] addr_next;

  // Paused pages advance only on step; running pages only on the dwell timeout.
  assign page_done = scan_en ? (cnt == DWELL_LAST) : step;
  assign addr_next = (regAddr == ADDR_LAST) ? 5'd0 : regAddr + 5'd1;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SETTLE;
      cnt        <= '0;
      regAddr    <= 5'd0;
      page_hi    <= 1'b0;
      blank      <= 1'b1;
      data_q     <= 32'd0;
      shown_addr <= 5'd0;
    end else begin
      case (state)
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
`ifdef SM_SCAN_SKIP_ZERO_EN
            if (regData == 32'd0) begin
              // Zero register: move on, leave whatever is on the display.
              regAddr <= addr_next;
            end else begin
              data_q     <= regData;
              shown_addr <= regAddr;
              blank      <= 1'b0;
              page_hi    <= 1'b0;
              state      <= SHOW_LO;
            end
`else
            data_q     <= regData;
            shown_addr <= regAddr;
            blank      <= 1'b0;
            page_hi    <= 1'b0;
            state      <= SHOW_LO;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHOW_LO: begin
          if (page_done) begin
            page_hi <= 1'b1;
            cnt     <= '0;
            state   <= SHOW_HI;
          end else if (scan_en) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHOW_HI: begin
          if (page_done) begin
            regAddr <= addr_next;
            cnt     <= '0;
            state   <= SETTLE;
          end else if (scan_en) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= SETTLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  logic [15:0] half;
  assign half = page_hi ? data_q[31:16] : data_q[15:0];

  sm_hex_digit u_hex0 (.nibble(half[3:0]),              .dp_on(1'b0),    .blank(blank), .seg(hex0));
  sm_hex_digit u_hex1 (.nibble(half[7:4]),              .dp_on(1'b0),    .blank(blank), .seg(hex1));
  sm_hex_digit u_hex2 (.nibble(half[11:8]),             .dp_on(1'b0),    .blank(blank), .seg(hex2));
  sm_hex_digit u_hex3 (.nibble(half[15:12]),            .dp_on(1'b0),    .blank(blank), .seg(hex3));
  sm_hex_digit u_hex4 (.nibble(shown_addr[3:0]),        .dp_on(page_hi), .blank(blank), .seg(hex4));
  sm_hex_digit u_hex5 (.nibble({3'b000, shown_addr[4]}), .dp_on(1'b0),    .blank(blank), .seg(hex5));

endmodule

// File: tb/tb_sm_reg_scanner.sv
// Directed bench for sm_reg_scanner with SETTLE_CYC=2, DWELL_CYC=3, ADDR_MAX=3.
// regData model: 32'h1000_0000*addr + addr + 1 (0 at addr 1 when zero_at1 is set).
// Display words are {hex5,hex4,hex3,hex2,hex1,hex0}; digit codes are active-low:
// 0=C0 1=F9 2=A4 3=B0 4=99, and with dp lit 0=40 1=79 2=24 3=30.
module tb_sm_reg_scanner;

  logic        clk;
  logic        rst_n;
  logic        scan_en;
  logic        step;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        page_hi;
  logic [1:0]  dbg_state;
  logic        zero_at1;

  int checks;
  int errors;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    regData = 32'h1000_0000 * 32'(regAddr) + 32'(regAddr) + 32'd1;
    if (zero_at1 && regAddr == 5'd1) regData = 32'd0;
  end

  sm_reg_scanner #(.SETTLE_CYC(2), .DWELL_CYC(3), .ADDR_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .step(step),
    .regAddr(regAddr), .regData(regData),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .page_hi(page_hi), .dbg_state(dbg_state)
  );

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] disp();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    zero_at1 = 1'b0;
    rst_n    = 1'b0;
    scan_en  = 1'b0;
    step     = 1'b0;
    tick(2);

    // reset state
    check("rst_disp",    disp(), 48'hFFFF_FFFF_FFFF);
    check("rst_addr",    48'(regAddr), 48'd0);
    check("rst_page_hi", 48'(page_hi), 48'd0);
    check("rst_state",   48'(dbg_state), 48'd0);

    // first page appears on the 2nd edge after release
    rst_n = 1'b1;
    tick(1);
    check("settle_blank", disp(), 48'hFFFF_FFFF_FFFF);
    tick(1);
    check("a0_lo_disp", disp(), 48'hC0C0_C0C0_C0F9);
    check("a0_lo_page", 48'(page_hi), 48'd0);

    // auto-advance: high page after 3 cycles, next address after 3 more
    scan_en = 1'b1;
    tick(2);
    check("a0_lo_hold", 48'(page_hi), 48'd0);
    tick(1);
    check("a0_hi_page", 48'(page_hi), 48'd1);
    check("a0_hi_disp", disp(), 48'hC040_C0C0_C0C0);
    tick(2);
    check("a0_hi_addr", 48'(regAddr), 48'd0);
    tick(1);
    check("a1_addr",    48'(regAddr), 48'd1);
    check("a1_settle_keep", disp(), 48'hC040_C0C0_C0C0);
    tick(1);
    check("a1_settle_keep2", disp(), 48'hC040_C0C0_C0C0);
    tick(1);
    check("a1_lo_disp", disp(), 48'hC0F9_C0C0_C0A4);

    // free-run through addr 3 and wrap; address never exceeds 3
    for (int i = 0; i < 16; i++) begin
      tick(1);
      check("addr_range", 48'(regAddr <= 5'd3), 48'd1);
    end
    check("a3_lo_disp", disp(), 48'hC0B0_C0C0_C099);
    check("a3_addr",    48'(regAddr), 48'd3);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("addr_range", 48'(regAddr <= 5'd3), 48'd1);
    end
    check("wrap_addr", 48'(regAddr), 48'd0);
    check("a3_hi_keep", disp(), 48'hC030_B0C0_C0C0);

    // step during SETTLE is ignored
    scan_en = 1'b0;
    pulse_step();
    check("settle_step_state", 48'(dbg_state), 48'd0);
    check("settle_step_page",  48'(page_hi), 48'd1);
    tick(1);
    check("wrap_a0_lo", disp(), 48'hC0C0_C0C0_C0F9);
    check("wrap_a0_state", 48'(dbg_state), 48'd1);

    // paused for 20 cycles: nothing moves
    tick(20);
    check("pause_disp", disp(), 48'hC0C0_C0C0_C0F9);
    check("pause_page", 48'(page_hi), 48'd0);

    // single steps walk the pages
    pulse_step();
    check("step_a0_hi", disp(), 48'hC040_C0C0_C0C0);
    pulse_step();
    check("step_a1_addr", 48'(regAddr), 48'd1);
    tick(2);
    check("step_a1_lo", disp(), 48'hC0F9_C0C0_C0A4);
    pulse_step();
    check("step_a1_hi", disp(), 48'hC079_F9C0_C0C0);
    pulse_step();
    tick(2);
    check("step_a2_lo", disp(), 48'hC0A4_C0C0_C0B0);
    pulse_step();
    check("step_a2_hi", disp(), 48'hC024_A4C0_C0C0);

    // reset in the middle of SHOW_HI at addr 2
    rst_n = 1'b0;
    tick(1);
    check("midrst_disp",  disp(), 48'hFFFF_FFFF_FFFF);
    check("midrst_addr",  48'(regAddr), 48'd0);
    check("midrst_page",  48'(page_hi), 48'd0);
    check("midrst_state", 48'(dbg_state), 48'd0);
    rst_n = 1'b1;
    tick(2);
    check("rerun_a0_lo", disp(), 48'hC0C0_C0C0_C0F9);

    // counter freezes while paused and resumes; step ignored while running
    scan_en = 1'b1;
    tick(1);
    scan_en = 1'b0;
    tick(5);
    check("frozen_page", 48'(page_hi), 48'd0);
    scan_en = 1'b1;
    step    = 1'b1;
    tick(1);
    step    = 1'b0;
    check("resume_page_lo", 48'(page_hi), 48'd0);
    tick(1);
    check("resume_page_hi", 48'(page_hi), 48'd1);

`ifdef SM_SCAN_SKIP_ZERO_EN
    // addr 1 reads zero and must be skipped without touching the display
    zero_at1 = 1'b1;
    scan_en  = 1'b0;
    rst_n    = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("skip_a0_lo", disp(), 48'hC0C0_C0C0_C0F9);
    scan_en = 1'b1;
    tick(6);
    check("skip_a1_addr", 48'(regAddr), 48'd1);
    tick(2);
    check("skip_a2_addr", 48'(regAddr), 48'd2);
    check("skip_keep",    disp(), 48'hC040_C0C0_C0C0);
    tick(2);
    check("skip_a2_lo",   disp(), 48'hC0A4_C0C0_C0B0);
    check("skip_a2_page", 48'(page_hi), 48'd0);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
